// File: rtl/onchip_line_writer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | onchip_line_writer_pkg                                             |
// | Shared types and constants for the byte-to-word Avalon writer.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package onchip_line_writer_pkg;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 8;
  localparam int CNT_W          = 3;

  localparam logic [BYTES_PER_WORD-1:0] BE_NONE = 4'b0000;
  localparam logic [BYTES_PER_WORD-1:0] BE_ALL  = 4'b1111;

  // One-hot lane enable for byte slot idx.
  function automatic logic [BYTES_PER_WORD-1:0] lane_bit(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onchip_line_writer_byte_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | byte_packer                                                        |
// | Little-endian byte-lane packer with byte count and lane enables.   |
// | clear empties the word; clear+load starts a fresh word at lane 0.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module byte_packer
  import onchip_line_writer_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             load,
  input  logic                             clear,
  input  logic [LANE_W-1:0]                data,
  output logic [BYTES_PER_WORD*LANE_W-1:0] word,
  output logic [BYTES_PER_WORD-1:0]        be,
  output logic [CNT_W-1:0]                 count
);

  logic [BYTES_PER_WORD*LANE_W-1:0] lanes_q, lanes_d;
  logic [BYTES_PER_WORD-1:0]        be_q, be_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic [CNT_W-1:0]                 base_cnt;
  logic [BYTES_PER_WORD-1:0]        lane_sel;

  // Next lane contents: optionally clear, then insert the byte at the next free lane.
  always_comb begin
    base_cnt = clear ? '0 : count_q;
    lane_sel = lane_bit(base_cnt[1:0]);
    lanes_d  = clear ? '0 : lanes_q;
    be_d     = clear ? BE_NONE : be_q;
    count_d  = base_cnt;
    if (load) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (lane_sel[k]) lanes_d[k*LANE_W +: LANE_W] = data;
      end
      be_d    = be_d | lane_sel;
      count_d = base_cnt + 3'd1;
    end
  end

  // Lane, enable and count registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lanes_q <= '0;
      be_q    <= BE_NONE;
      count_q <= '0;
    end else begin
      lanes_q <= lanes_d;
      be_q    <= be_d;
      count_q <= count_d;
    end
  end

  assign word  = lanes_q;
  assign be    = be_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/onchip_line_writer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | onchip_line_writer                                                 |
// | Packs a valid/ready byte stream into 32-bit words and writes them  |
// | to consecutive word addresses of an Avalon-MM on-chip RAM.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module onchip_line_writer
  import onchip_line_writer_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DEPTH     = 16384,
  parameter int BASE_WORD = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sof,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] av_address,
  output logic [3:0]        av_byteenable,
  output logic              av_chipselect,
  output logic              av_write,
  output logic [31:0]       av_writedata,
  input  logic              av_waitrequest,
  output logic [ADDR_W:0]   words_written,
  output logic              done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                overflow_q, overflow_d;
  logic                sof_pend_q, sof_pend_d;
  logic                last_q, last_d;
  logic                done_q, done_d;

  logic                pk_load, pk_clear;
  logic [31:0]         pk_word;
  logic [3:0]          pk_be;
  logic [CNT_W-1:0]    pk_count;
  logic                accept;
  logic                window_full;
  logic                completes_word;

  byte_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pk_load),
    .clear   (pk_clear),
    .data    (in_data),
    .word    (pk_word),
    .be      (pk_be),
    .count   (pk_count)
  );

  assign in_ready       = (state_q == FILL) && reset_n;
  assign accept         = in_valid && in_ready;
  assign window_full    = (words_q == DEPTH_W);
  // A sof in the same cycle restarts the word, so that byte lands in lane 0.
  assign completes_word = !sof && (pk_count == 3'd3);

  // Next-state, counters, sof latch and packer control.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    words_d    = words_q;
    overflow_d = overflow_q;
    sof_pend_d = sof_pend_q;
    last_d     = last_q;
    done_d     = 1'b0;
    pk_load    = 1'b0;
    pk_clear   = 1'b0;
    case (state_q)
      FILL: begin
        if (sof) begin
          addr_d     = BASE_ADDR;
          words_d    = '0;
          overflow_d = 1'b0;
          pk_clear   = 1'b1;
        end
        if (accept) begin
          if (window_full && !sof) begin
            overflow_d = 1'b1;
          end else begin
            pk_load = 1'b1;
            last_d  = in_last;
            if (in_last || completes_word) state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (sof) sof_pend_d = 1'b1;
        if (!av_waitrequest) begin
          pk_clear = 1'b1;
          state_d  = FILL;
          done_d   = last_q;
          last_d   = 1'b0;
          if (sof || sof_pend_q) begin
            addr_d     = BASE_ADDR;
            words_d    = '0;
            overflow_d = 1'b0;
            sof_pend_d = 1'b0;
          end else begin
            words_d = words_q + 1'b1;
            // Hold the address on the last word so it never leaves the window.
            if ((words_q + 1'b1) != DEPTH_W) addr_d = addr_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= FILL;
      addr_q     <= BASE_ADDR;
      words_q    <= '0;
      overflow_q <= 1'b0;
      sof_pend_q <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      overflow_q <= overflow_d;
      sof_pend_q <= sof_pend_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign av_write      = (state_q == WRITE);
  assign av_chipselect = (state_q == WRITE);
  assign av_address    = addr_q;
  assign av_writedata  = pk_word;
  assign av_byteenable = pk_be;
  assign words_written = words_q;
  assign done          = done_q;
  assign overflow      = overflow_q;

endmodule
`default_nettype wire
